fft_input_framer: RTL
=====================

// Module: fft_input_framer
// PURPOSE
// - Upstream loader for the 8-point FFT unit: accepts a stream of complex 16-bit samples over valid/ready.
// - Assembles N-sample frames and presents each as a parallel bus to the FFT's In_real/In_imag inputs.
// - Ping-pong double buffer: one bank fills while the other is presented, so streaming runs without bubbles.
// - Flags frames whose s_last marker is misaligned.
// PARAMETERS
// - N            8   samples per frame; power of 2 matching the FFT size
// - W            16  bits per real/imag component, two's complement
// - BIT_REVERSE  0   0 = present in natural order; 1 = present in bit-reversed order
// PORTS
// - clk          in   1      clock; all logic on posedge
// - reset        in   1      reset, asynchronous, active-low
// - s_valid      in   1      input sample valid
// - s_ready      out  1      framer can accept a sample
// - s_real       in   W      sample real part
// - s_imag       in   W      sample imaginary part
// - s_last       in   1      marks the final sample of a frame
// - frame_real   out  N*W    sample i at [i*W +: W]; feeds In_real[i]
// - frame_imag   out  N*W    same packing for the imaginary parts
// - frame_valid  out  1      presented frame is complete
// - frame_ready  in   1      downstream consumes the frame
// - frame_err    out  1      one-cycle pulse on an s_last misalignment
// - frame_cnt    out  16     count of committed frames; wraps 0xFFFF->0
// BEHAVIOUR
// - Reset (reset=0, async) clears:
//   - wr_idx=0, wr_bank=0, rd_bank=0, full[1:0]=0
//   - frame_valid=0, frame_err=0, frame_cnt=0, frame_real/imag=0
//   - s_ready=0 while in reset, 1 on the first cycle after release
// - s_ready = !full[wr_bank], combinational from registers.
// - Accept = s_valid && s_ready: writes the sample to bank[wr_bank][wr_idx], then wr_idx++.
// - Commit: accept at wr_idx==N-1 sets full[wr_bank], toggles wr_bank, clears wr_idx, increments frame_cnt.
//   - frame_valid rises the next cycle if that bank is rd_bank (latency 1 clk from the last accept).
// - Early s_last: accept with s_last=1 at wr_idx<N-1:
//   - partial frame discarded, wr_idx=0, bank not marked full
//   - frame_err pulses next cycle; frame_cnt unchanged
// - Missing s_last: accept at wr_idx==N-1 with s_last=0:
//   - frame still commits
//   - frame_err pulses next cycle
// - frame_valid = full[rd_bank].
//   - frame_real/imag = contents of bank[rd_bank], held stable while frame_valid && !frame_ready.
//   - BIT_REVERSE=1: output slot i carries the sample written at index bitrev(i).
// - Drain = frame_valid && frame_ready: clears full[rd_bank] and toggles rd_bank.
//   - The next bank, if full, is presented the following cycle (back-to-back frames, no bubble).
// - Commit and drain in the same cycle: they always target different banks; both take effect.
// - Both banks full: s_ready=0 until a drain; the drain frees the bank and s_ready rises the next cycle.
// - frame_ready is ignored while frame_valid=0; the output bus is don't-care then.
// - Arithmetic: samples are stored verbatim with no scaling or saturation.
//   - wr_idx is $clog2(N) bits and wraps only through commit or discard.
// - Reset mid-frame: the partial frame and any full banks are lost; no frame_err is generated.
// STRUCTURE
// - Shared package fft_pkg:
//   - FFT_N=8, FFT_W=16
//   - function bitrev(idx, log2n)
//   - frame-packing localparams
// - Sub-module fft_frame_bank: N x 2W register bank with write-enable and write index, parallel read-out.
//   - Instantiated twice.
// - Top level holds wr/rd bank pointers, full flags, wr_idx, the error pulse and the frame counter.
// TESTING
// - Reset, then stream x[i]=(i+1, -(i+1)) for i=0..7 with s_last on i=7 and frame_ready=1:
//   - frame_valid is high 1 clk after the 8th accept
//   - frame_real[0*W+:W]=1, slot 7=8, slot 7 imag=-8
//   - frame_cnt=1, frame_err=0
// - frame_ready=0, stream 24 samples continuously:
//   - s_ready falls after sample 16 and both banks are full
//   - frame 1 data stays stable
//   - raise frame_ready: frame 1 then frame 2 present back-to-back, s_ready returns
// - s_last on the 5th sample:
//   - frame_err pulses once, frame_cnt unchanged, no frame_valid
//   - the next 8 samples form a correct frame
// - 8 samples with no s_last: frame commits (frame_cnt+1) and frame_err pulses.
// - BIT_REVERSE=1, input 0..7: output slots read 0,4,2,6,1,5,3,7.
// - Assert reset after 4 samples, release, send a full frame:
//   - outputs 0 while in reset
//   - only the new frame appears; frame_cnt=1

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT front end: frame geometry and the
// index bit-reversal helper used when reordering samples for the FFT core.
package fft_pkg;

  localparam int FFT_N      = 8;
  localparam int FFT_W      = 16;
  localparam int FFT_LOG2N  = $clog2(FFT_N);
  localparam int FRAME_BITS = FFT_N * FFT_W;

  // Reverse the low log2n bits of idx (e.g. 3 bits: 1 -> 4, 3 -> 6).
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned log2n);
    int unsigned r;
    r = 32'd0;
    for (int unsigned b = 32'd0; b < log2n; b++) begin
      r[log2n - 32'd1 - b] = idx[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of complex samples: indexed single-sample write port and a
// parallel read-out of all N samples in natural order.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int N = FFT_N,
  parameter int W = FFT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] widx,
  input  logic [W-1:0]         wreal,
  input  logic [W-1:0]         wimag,
  output logic [N*W-1:0]       rd_real,
  output logic [N*W-1:0]       rd_imag
);

  logic [N*W-1:0] mem_real_r;
  logic [N*W-1:0] mem_imag_r;

  // Sample storage; cleared on reset so the presented bus reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_real_r <= '0;
      mem_imag_r <= '0;
    end else if (we) begin
      mem_real_r[widx*W +: W] <= wreal;
      mem_imag_r[widx*W +: W] <= wimag;
    end
  end

  assign rd_real = mem_real_r;
  assign rd_imag = mem_imag_r;

endmodule

// File: rtl/fft_input_framer.sv
// Streaming loader for the FFT: packs valid/ready samples into N-sample
// frames using two ping-pong banks, presents a full bank as a parallel bus,
// and flags frames whose s_last marker does not sit on the final sample.
module fft_input_framer
  import fft_pkg::*;
#(
  parameter int N           = FFT_N,
  parameter int W           = FFT_W,
  parameter int BIT_REVERSE = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_real,
  input  logic [W-1:0]   s_imag,
  input  logic           s_last,
  output logic [N*W-1:0] frame_real,
  output logic [N*W-1:0] frame_imag,
  output logic           frame_valid,
  input  logic           frame_ready,
  output logic           frame_err,
  output logic [15:0]    frame_cnt
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  logic [IW-1:0] wr_idx_r, wr_idx_n;
  logic          wr_bank_r, wr_bank_n;
  logic          rd_bank_r, rd_bank_n;
  logic [1:0]    full_r, full_n;
  logic          ready_en_r;
  logic          frame_err_r;
  logic [15:0]   frame_cnt_r;

  logic          accept_s, at_last_s, commit_s, discard_s, misalign_s, drain_s;
  logic [N*W-1:0] bank0_real_s, bank0_imag_s, bank1_real_s, bank1_imag_s;
  logic [N*W-1:0] sel_real_s, sel_imag_s;

  // ready_en_r keeps s_ready low while reset is held, even though the
  // full flags are already clear then.
  assign s_ready     = ready_en_r && !full_r[wr_bank_r];
  assign accept_s    = s_valid && s_ready;
  assign at_last_s   = (wr_idx_r == LAST_IDX);
  assign commit_s    = accept_s && at_last_s;
  assign discard_s   = accept_s && s_last && !at_last_s;
  assign misalign_s  = accept_s && (s_last != at_last_s);
  assign frame_valid = full_r[rd_bank_r];
  assign drain_s     = frame_valid && frame_ready;
  assign frame_err   = frame_err_r;
  assign frame_cnt   = frame_cnt_r;

  // Next-state for write pointer, bank pointers and full flags. A commit
  // and a drain in the same cycle always touch different banks.
  always_comb begin
    full_n    = full_r;
    wr_idx_n  = wr_idx_r;
    wr_bank_n = wr_bank_r;
    rd_bank_n = rd_bank_r;
    if (commit_s) begin
      full_n[wr_bank_r] = 1'b1;
      wr_bank_n         = ~wr_bank_r;
      wr_idx_n          = '0;
    end else if (discard_s) begin
      wr_idx_n = '0;
    end else if (accept_s) begin
      wr_idx_n = wr_idx_r + IDX_ONE;
    end else begin
      wr_idx_n = wr_idx_r;
    end
    if (drain_s) begin
      full_n[rd_bank_r] = 1'b0;
      rd_bank_n         = ~rd_bank_r;
    end else begin
      rd_bank_n = rd_bank_r;
    end
  end

  // Control state, error pulse and committed-frame counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx_r    <= '0;
      wr_bank_r   <= 1'b0;
      rd_bank_r   <= 1'b0;
      full_r      <= 2'b00;
      ready_en_r  <= 1'b0;
      frame_err_r <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      wr_idx_r    <= wr_idx_n;
      wr_bank_r   <= wr_bank_n;
      rd_bank_r   <= rd_bank_n;
      full_r      <= full_n;
      ready_en_r  <= 1'b1;
      frame_err_r <= misalign_s;
      if (commit_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
    end
  end

  fft_frame_bank #(.N(N), .W(W)) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .we      (accept_s && (wr_bank_r == 1'b0)),
    .widx    (wr_idx_r),
    .wreal   (s_real),
    .wimag   (s_imag),
    .rd_real (bank0_real_s),
    .rd_imag (bank0_imag_s)
  );

  fft_frame_bank #(.N(N), .W(W)) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .we      (accept_s && (wr_bank_r == 1'b1)),
    .widx    (wr_idx_r),
    .wreal   (s_real),
    .wimag   (s_imag),
    .rd_real (bank1_real_s),
    .rd_imag (bank1_imag_s)
  );

  assign sel_real_s = rd_bank_r ? bank1_real_s : bank0_real_s;
  assign sel_imag_s = rd_bank_r ? bank1_imag_s : bank0_imag_s;

  // Output slot ordering is fixed at elaboration: natural or bit-reversed.
  for (genvar i = 0; i < N; i++) begin : g_slot
    localparam int SRC = (BIT_REVERSE != 0) ? int'(bitrev(i, IW)) : i;
    assign frame_real[i*W +: W] = sel_real_s[SRC*W +: W];
    assign frame_imag[i*W +: W] = sel_imag_s[SRC*W +: W];
  end

endmodule
